ex_branch_resolve: RTL and testbench
====================================

# ex_branch_resolve

Execute-stage branch/jump resolution unit, directly downstream of the decode-to-execute jump/branch pipeline register. Evaluates the branch condition or jump target for the instruction currently in E and compares it against the prediction made in decode. On a misprediction it raises `fail_predict` with the corrected PC, which flushes that pipeline register and fetch. It also owns the 4-entry 2-bit predictor table that decode reads, plus branch/mispredict statistics counters.

## Interface
- No parameters; widths are fixed: PC/imm 13 bits, predictor index 2 bits.
- CLK  in  1  clock, all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- branch_numberE  in  2  predictor table index of the E instruction.
- pcEj  in  13  PC of the E instruction.
- reg_data1Ej, reg_data2Ej  in  32  rs1 and rs2 operands.
- immEj  in  13  sign-extended-in-13-bit branch/jump immediate.
- jump_codeEj  in  2  00 none, 01 JAL, 10 JALR, 11 treated as none.
- branch_codeEj  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 treated as none.
- stateEj  in  2  predictor counter snapshot taken in decode; bit 1 is the predicted-taken bit.
- pred_index  in  2  decode-side read index.
- pred_state  out  2  combinational table read for decode.
- fail_predict  out  1  combinational; misprediction or JALR redirect.
- redirect_pc  out  13  corrected fetch PC, valid when fail_predict=1.
- link_pc  out  13  pcEj+4, the writeback value for JAL/JALR.
- branch_count  out  16  resolved conditional branches, saturating.
- mispredict_count  out  16  fail_predict events, saturating.

## Operation
- Valid branch: branch_codeEj in 001..110. Valid jump: jump_codeEj in 01..10. Both zero means bubble. Stall and flush cycles arrive as bubbles.
- Conditions:
  - BEQ/BNE compare equality.
  - BLT/BGE use signed 32-bit compare.
  - BLTU/BGEU use unsigned 32-bit compare.
- Target arithmetic, all modulo 2^13:
  - Branch target = pcEj+immEj.
  - Fallthrough = pcEj+4.
  - JALR target = (reg_data1Ej[12:0]+immEj) with bit 0 cleared.
- Branch outcomes:
  - fail_predict = taken XOR stateEj[1].
  - redirect_pc = taken ? target : fallthrough.
- JAL is redirected in decode: fail_predict=0 here.
- JALR: fail_predict=1 always, redirect_pc = JALR target.
- Bubble: fail_predict=0, redirect_pc=0.
- If both codes are non-zero (illegal), the branch path has priority and the jump is ignored.
- Predictor table: 4 entries of 2-bit saturating counters.
  - On each valid branch, entry[branch_numberE] increments if taken (saturating at 11) or decrements if not taken (saturating at 00).
  - The update uses the table's current entry value, not stateEj.
  - Jumps and bubbles leave the table unchanged.
- pred_state = entry[pred_index] with write-through bypass. If a branch update to the same index occurs this cycle, pred_state shows the post-update value.
- Counters:
  - branch_count increments on every valid branch.
  - mispredict_count increments on every fail_predict=1.
  - Both saturate at 16'hFFFF.

## Timing
- Resolution is zero-latency: fail_predict, redirect_pc, link_pc and pred_state are combinational from the current inputs and table.
- Table and counter updates take effect at the rising edge ending the resolve cycle.
- Back-to-back branches to the same index each apply their own update in sequence; no update is lost.
- The cycle after a fail_predict, the upstream register presents a bubble. No special handling is required here.
- Reset values:
  - All table entries = 2'b01 (weakly not-taken).
  - branch_count = 0, mispredict_count = 0.
  - Combinational outputs follow the inputs: with bubble inputs, fail_predict=0 and pred_state=01.
- RST asserted mid-operation overrides any same-cycle update: table and counters take their reset values at that edge.

## Test plan
- Reset, then BEQ with pc=0x0100, imm=0x0020, rs1=rs2=5, stateEj=01, index=2:
  - Same cycle: fail_predict=1, redirect_pc=0x0120.
  - Next cycle: entry2=10, branch_count=1, mispredict_count=1.
- BLT with rs1=0xFFFFFFFF, rs2=1, stateEj=10 → taken, fail_predict=0. Same operands with BLTU, stateEj=10 → not taken, fail_predict=1, redirect_pc=pc+4.
- Four consecutive taken branches to index 0 → entry0 goes 01→10→11→11 (saturates). pred_index=0 during the first update shows 10 via bypass.
- JALR with rs1=0x00001003, imm=0x0004, pc=0x0200 → fail_predict=1, redirect_pc=0x1006, link_pc=0x0204, table unchanged. JAL → fail_predict=0, link_pc=pc+4.
- pc=0x1FFC with a taken branch, imm=0x0008 → redirect_pc=0x0004 (wrap). Not-taken at pc=0x1FFC → redirect fallthrough 0x0000.
- Preload mispredict_count=0xFFFF via 65535 JALRs, then one more JALR → count holds at 0xFFFF. Asserting RST in the same cycle as a branch update → all entries=01 and both counters=0 next cycle.

Source files
------------

// File: rtl/ex_branch_resolve.sv
// ----------------------------------------------------------------------------
// ex_branch_resolve
//
// Execute-stage branch/jump resolution. This block checks the instruction in E
// against the prediction that decode made for it. On a misprediction, or on any
// JALR, it raises fail_predict and supplies the corrected fetch PC. It also owns
// the 4-entry 2-bit predictor table that decode reads, and two saturating
// statistics counters.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   branch_numberE [1:0]      predictor entry that the E branch updates
//   pcEj [12:0]               PC of the E instruction
//   reg_data1Ej/2Ej [31:0]    rs1 / rs2 operands
//   immEj [12:0]              branch/jump immediate (already 13-bit)
//   jump_codeEj [1:0]         01 JAL, 10 JALR, others none
//   branch_codeEj [2:0]       001..110 BEQ,BNE,BLT,BGE,BLTU,BGEU, others none
//   stateEj [1:0]             counter snapshot from decode, bit 1 = predicted
//   pred_index [1:0]          decode-side table read index
//   pred_state [1:0]          table read, with same-cycle update bypass
//   fail_predict              redirect request (mispredict or JALR)
//   redirect_pc [12:0]        corrected fetch PC when fail_predict=1
//   link_pc [12:0]            pcEj+4, writeback value for JAL/JALR
//   branch_count [15:0]       resolved conditional branches, saturating
//   mispredict_count [15:0]   fail_predict events, saturating
// ----------------------------------------------------------------------------
module ex_branch_resolve (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  branch_numberE,
   input  logic [12:0] pcEj,
   input  logic [31:0] reg_data1Ej,
   input  logic [31:0] reg_data2Ej,
   input  logic [12:0] immEj,
   input  logic [1:0]  jump_codeEj,
   input  logic [2:0]  branch_codeEj,
   input  logic [1:0]  stateEj,
   input  logic [1:0]  pred_index,
   output logic [1:0]  pred_state,
   output logic        fail_predict,
   output logic [12:0] redirect_pc,
   output logic [12:0] link_pc,
   output logic [15:0] branch_count,
   output logic [15:0] mispredict_count
);

   logic        branch_valid;
   logic        is_jalr;
   logic        taken;
   logic [12:0] branch_target;
   logic [12:0] fallthrough;
   logic [12:0] jalr_target;
   logic [1:0]  cur_entry;
   logic [1:0]  upd_val;

   logic [1:0]  table_q [4];
   logic [1:0]  table_d [4];
   logic [15:0] branch_count_q, branch_count_d;
   logic [15:0] mispredict_count_q, mispredict_count_d;

   // A legal branch code wins over any jump code in the same instruction.
   assign branch_valid = (branch_codeEj != 3'b000) && (branch_codeEj != 3'b111);
   assign is_jalr      = !branch_valid && (jump_codeEj == 2'b10);

   assign branch_target = pcEj + immEj;
   assign fallthrough   = pcEj + 13'd4;
   assign jalr_target   = (reg_data1Ej[12:0] + immEj) & ~13'd1;
   assign link_pc       = fallthrough;

   always_comb begin
      taken = 1'b0;
      case (branch_codeEj)
         3'b001:  taken = (reg_data1Ej == reg_data2Ej);
         3'b010:  taken = (reg_data1Ej != reg_data2Ej);
         3'b011:  taken = ($signed(reg_data1Ej) <  $signed(reg_data2Ej));
         3'b100:  taken = ($signed(reg_data1Ej) >= $signed(reg_data2Ej));
         3'b101:  taken = (reg_data1Ej <  reg_data2Ej);
         3'b110:  taken = (reg_data1Ej >= reg_data2Ej);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      fail_predict = 1'b0;
      redirect_pc  = 13'd0;
      if (branch_valid) begin
         fail_predict = taken ^ stateEj[1];
         redirect_pc  = taken ? branch_target : fallthrough;
      end else if (is_jalr) begin
         // JAL was already redirected in decode; only JALR needs it here.
         fail_predict = 1'b1;
         redirect_pc  = jalr_target;
      end
   end

   // Update is based on the live table entry, not the decode snapshot, so
   // back-to-back branches to one entry each see the previous update.
   assign cur_entry = table_q[branch_numberE];

   always_comb begin
      if (taken) upd_val = (cur_entry == 2'b11) ? 2'b11 : cur_entry + 2'b01;
      else       upd_val = (cur_entry == 2'b00) ? 2'b00 : cur_entry - 2'b01;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_entry
         assign table_d[gi] = (branch_valid && (branch_numberE == 2'(gi))) ? upd_val : table_q[gi];

         always_ff @(posedge CLK) begin
            if (RST) table_q[gi] <= 2'b01;
            else     table_q[gi] <= table_d[gi];
         end
      end
   endgenerate

   // Decode sees the post-update value when it reads the entry being written.
   assign pred_state = table_d[pred_index];

   assign branch_count_d = (branch_valid && (branch_count_q != 16'hFFFF))
                           ? branch_count_q + 16'd1 : branch_count_q;
   assign mispredict_count_d = (fail_predict && (mispredict_count_q != 16'hFFFF))
                               ? mispredict_count_q + 16'd1 : mispredict_count_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         branch_count_q     <= 16'd0;
         mispredict_count_q <= 16'd0;
      end else begin
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// ----------------------------------------------------------------------------
// tb_ex_branch_resolve
//
// Directed-vector bench for ex_branch_resolve. Inputs change 1 time unit after
// the rising edge. Combinational outputs are checked 1 unit later. Registered
// state is checked after the following edge.
// ----------------------------------------------------------------------------
module tb_ex_branch_resolve;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  branch_numberE;
   logic [12:0] pcEj;
   logic [31:0] reg_data1Ej;
   logic [31:0] reg_data2Ej;
   logic [12:0] immEj;
   logic [1:0]  jump_codeEj;
   logic [2:0]  branch_codeEj;
   logic [1:0]  stateEj;
   logic [1:0]  pred_index;
   logic [1:0]  pred_state;
   logic        fail_predict;
   logic [12:0] redirect_pc;
   logic [12:0] link_pc;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   int total = 0;
   int bad   = 0;

   ex_branch_resolve dut (
      .CLK(CLK), .RST(RST),
      .branch_numberE(branch_numberE), .pcEj(pcEj),
      .reg_data1Ej(reg_data1Ej), .reg_data2Ej(reg_data2Ej),
      .immEj(immEj), .jump_codeEj(jump_codeEj), .branch_codeEj(branch_codeEj),
      .stateEj(stateEj), .pred_index(pred_index), .pred_state(pred_state),
      .fail_predict(fail_predict), .redirect_pc(redirect_pc), .link_pc(link_pc),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic bubble();
      branch_codeEj = 3'b000;
      jump_codeEj   = 2'b00;
      branch_numberE = 2'd0;
      pcEj = 13'd0; immEj = 13'd0;
      reg_data1Ej = 32'd0; reg_data2Ej = 32'd0;
      stateEj = 2'b00;
   endtask

   task automatic br(input logic [2:0] code, input logic [12:0] pc, input logic [12:0] imm,
                     input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic [1:0] st, input logic [1:0] idx);
      branch_codeEj = code; jump_codeEj = 2'b00;
      pcEj = pc; immEj = imm; reg_data1Ej = rs1; reg_data2Ej = rs2;
      stateEj = st; branch_numberE = idx;
   endtask

   task automatic jmp(input logic [1:0] code, input logic [12:0] pc, input logic [12:0] imm,
                      input logic [31:0] rs1);
      branch_codeEj = 3'b000; jump_codeEj = code;
      pcEj = pc; immEj = imm; reg_data1Ej = rs1; reg_data2Ej = 32'd0;
      stateEj = 2'b00; branch_numberE = 2'd3;
   endtask

   logic [1:0] exp_seq [4];

   initial begin
      exp_seq[0] = 2'b10; exp_seq[1] = 2'b11; exp_seq[2] = 2'b11; exp_seq[3] = 2'b11;
      RST = 1'b1; pred_index = 2'd0;
      bubble();
      tick(); tick();
      RST = 1'b0;
      #1;
      check("rst_fail", 32'(fail_predict), 0);
      check("rst_redirect", 32'(redirect_pc), 0);
      check("rst_pred", 32'(pred_state), 1);
      check("rst_bc", 32'(branch_count), 0);
      check("rst_mc", 32'(mispredict_count), 0);
      tick();

      // BEQ taken, predicted not-taken
      br(3'b001, 13'h0100, 13'h0020, 32'd5, 32'd5, 2'b01, 2'd2);
      pred_index = 2'd2;
      #1;
      check("beq_fail", 32'(fail_predict), 1);
      check("beq_redirect", 32'(redirect_pc), 32'h0120);
      check("beq_bypass", 32'(pred_state), 2);
      tick();
      bubble();
      #1;
      check("beq_entry2", 32'(pred_state), 2);
      check("beq_bc", 32'(branch_count), 1);
      check("beq_mc", 32'(mispredict_count), 1);

      // BLT signed: -1 < 1 taken
      br(3'b011, 13'h0300, 13'h0010, 32'hFFFF_FFFF, 32'd1, 2'b10, 2'd1);
      #1;
      check("blt_fail", 32'(fail_predict), 0);
      check("blt_redirect", 32'(redirect_pc), 32'h0310);
      tick();
      // BLTU unsigned: 0xFFFFFFFF < 1 false
      br(3'b101, 13'h0300, 13'h0010, 32'hFFFF_FFFF, 32'd1, 2'b10, 2'd1);
      pred_index = 2'd1;
      #1;
      check("bltu_fail", 32'(fail_predict), 1);
      check("bltu_redirect", 32'(redirect_pc), 32'h0304);
      check("bltu_bypass", 32'(pred_state), 1);
      tick();
      bubble();
      #1;
      check("bltu_bc", 32'(branch_count), 3);
      check("bltu_mc", 32'(mispredict_count), 2);

      // Four taken branches to entry 0: 01 -> 10 -> 11 -> 11 -> 11
      pred_index = 2'd0;
      for (int i = 0; i < 4; i++) begin
         br(3'b010, 13'h0040, 13'h0100, 32'd1, 32'd2, 2'b10, 2'd0);
         #1;
         check($sformatf("sat_bypass%0d", i), 32'(pred_state), 32'(exp_seq[i]));
         check($sformatf("sat_fail%0d", i), 32'(fail_predict), 0);
         tick();
      end
      bubble();
      #1;
      check("sat_entry0", 32'(pred_state), 3);
      check("sat_bc", 32'(branch_count), 7);

      // BGE -1 >= 1 false, entry3 01 -> 00
      br(3'b100, 13'h0500, 13'h0040, 32'hFFFF_FFFF, 32'd1, 2'b01, 2'd3);
      #1;
      check("bge_fail", 32'(fail_predict), 0);
      check("bge_redirect", 32'(redirect_pc), 32'h0504);
      tick();
      bubble();
      pred_index = 2'd3;
      #1;
      check("bge_entry3", 32'(pred_state), 0);

      // JALR and JAL
      pred_index = 2'd0;
      jmp(2'b10, 13'h0200, 13'h0004, 32'h0000_1003);
      #1;
      check("jalr_fail", 32'(fail_predict), 1);
      check("jalr_redirect", 32'(redirect_pc), 32'h1006);
      check("jalr_link", 32'(link_pc), 32'h0204);
      tick();
      jmp(2'b01, 13'h0400, 13'h0010, 32'd0);
      #1;
      check("jal_fail", 32'(fail_predict), 0);
      check("jal_link", 32'(link_pc), 32'h0404);
      tick();
      bubble();
      #1;
      check("jump_entry0", 32'(pred_state), 3);
      check("jump_bc", 32'(branch_count), 8);
      check("jump_mc", 32'(mispredict_count), 3);

      // PC wrap
      br(3'b001, 13'h1FFC, 13'h0008, 32'd7, 32'd7, 2'b10, 2'd1);
      #1;
      check("wrap_taken", 32'(redirect_pc), 32'h0004);
      check("wrap_taken_fail", 32'(fail_predict), 0);
      tick();
      br(3'b010, 13'h1FFC, 13'h0008, 32'd7, 32'd7, 2'b00, 2'd1);
      #1;
      check("wrap_ft", 32'(redirect_pc), 32'h0000);
      check("wrap_ft_fail", 32'(fail_predict), 0);
      tick();

      // Branch and JALR together: branch wins (taken, predicted taken)
      br(3'b001, 13'h0600, 13'h0020, 32'd3, 32'd3, 2'b10, 2'd2);
      jump_codeEj = 2'b10;
      #1;
      check("both_fail", 32'(fail_predict), 0);
      check("both_redirect", 32'(redirect_pc), 32'h0620);
      tick();
      // Code 111 is not a branch
      br(3'b111, 13'h0700, 13'h0020, 32'd3, 32'd3, 2'b00, 2'd2);
      #1;
      check("c7_fail", 32'(fail_predict), 0);
      check("c7_redirect", 32'(redirect_pc), 0);
      tick();
      bubble();
      pred_index = 2'd2;
      #1;
      check("both_entry2", 32'(pred_state), 3);
      check("both_bc", 32'(branch_count), 11);
      check("both_mc", 32'(mispredict_count), 3);

      // Saturate mispredict_count: 3 + 65532 = 0xFFFF, then one more
      jmp(2'b10, 13'h0000, 13'h0000, 32'd0);
      for (int i = 0; i < 65532; i++) tick();
      check("mc_full", 32'(mispredict_count), 32'hFFFF);
      tick();
      check("mc_hold", 32'(mispredict_count), 32'hFFFF);
      check("mc_bc", 32'(branch_count), 11);

      // Reset coincident with a branch update
      br(3'b001, 13'h0000, 13'h0010, 32'd1, 32'd1, 2'b01, 2'd0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      bubble();
      for (int i = 0; i < 4; i++) begin
         pred_index = 2'(i);
         #1;
         check($sformatf("rst2_entry%0d", i), 32'(pred_state), 1);
      end
      check("rst2_bc", 32'(branch_count), 0);
      check("rst2_mc", 32'(mispredict_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
